// File: rtl/cpri_deframe_pkg.sv
// Shared types and default geometry for the CPRI chip deframer and its SOP lock FSM.
package cpri_deframe_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    localparam int CHIP_LEN_DEF     = 96;
    localparam int CHIP_PER_SYM_DEF = 132;
    localparam int SYM_NUM_DEF      = 5;

    localparam int WORD_IW = 7;
    localparam int CHIP_IW = 8;
    localparam int SYM_IW  = 3;
    localparam int LANES   = 8;

endpackage

// File: rtl/cpri_sop_lock_fsm.sv
// SOP cadence lock FSM: word counter plus good/miss counting over the registered SOP.
module cpri_sop_lock_fsm
    import cpri_deframe_pkg::*;
#(
    parameter int CHIP_LEN = CHIP_LEN_DEF,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sop_i,
    output logic               locked_o,
    output logic [WORD_IW-1:0] word_idx_o,
    output logic               wrap_o,
    output logic               err_o,
    output logic               lock_loss_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    lock_state_e        state_q, state_d;
    logic [WORD_IW-1:0] word_q, word_d, cur_word;
    logic [GW-1:0]      good_q, good_d;
    logic [MW-1:0]      miss_q, miss_d;
    logic               lock_now, err, loss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            word_q  <= '0;
            good_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_q;
        cur_word = word_q;
        lock_now = 1'b0;
        err      = 1'b0;
        loss     = 1'b0;
        unique case (state_q)
            HUNT: begin
                good_d = '0;
                miss_d = '0;
                if (sop_i) begin
                    cur_word = '0;
                    good_d   = GW'(1);
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (sop_i) begin
                    cur_word = '0;
                    if (word_q != '0) begin
                        good_d = GW'(1);
                    end else if (good_q == GW'(LOCK_CNT - 1)) begin
                        good_d   = '0;
                        miss_d   = '0;
                        lock_now = 1'b1;
                        state_d  = LOCKED;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end else if (word_q == '0) begin
                    good_d  = '0;
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                // Stray SOPs are reported but never resync the word counter here.
                if (sop_i && word_q == '0) begin
                    miss_d = '0;
                end else if (sop_i || word_q == '0) begin
                    err = 1'b1;
                    if (miss_q == MW'(MISS_MAX - 1)) begin
                        miss_d  = '0;
                        loss    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        miss_d = miss_q + MW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        word_d = (cur_word == WORD_IW'(CHIP_LEN - 1)) ? '0 : cur_word + WORD_IW'(1);
    end

    assign locked_o    = (state_q == LOCKED) || lock_now;
    assign word_idx_o  = cur_word;
    assign wrap_o      = (state_q == LOCKED) && (word_q == WORD_IW'(CHIP_LEN - 1));
    assign err_o       = err;
    assign lock_loss_o = loss;

endmodule

// File: rtl/cpri_chip_deframer.sv
// CPRI 8-lane chip deframer: locks to SOP cadence and tags words with word/chip/symbol position.
// Optional statistics counters are enabled by defining CPRI_DEFRAME_STAT_EN.
module cpri_chip_deframer
    import cpri_deframe_pkg::*;
#(
    parameter int DAT_DW       = 64,
    parameter int CHIP_LEN     = CHIP_LEN_DEF,
    parameter int CHIP_PER_SYM = CHIP_PER_SYM_DEF,
    parameter int SYM_NUM      = SYM_NUM_DEF,
    parameter int LOCK_CNT     = 3,
    parameter int MISS_MAX     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sop_cpri_i,
    input  logic [DAT_DW-1:0]  dat_cpri0_i,
    input  logic [DAT_DW-1:0]  dat_cpri1_i,
    input  logic [DAT_DW-1:0]  dat_cpri2_i,
    input  logic [DAT_DW-1:0]  dat_cpri3_i,
    input  logic [DAT_DW-1:0]  dat_cpri4_i,
    input  logic [DAT_DW-1:0]  dat_cpri5_i,
    input  logic [DAT_DW-1:0]  dat_cpri6_i,
    input  logic [DAT_DW-1:0]  dat_cpri7_i,
    output logic               vld_o,
    output logic               sym_sop_o,
    output logic               chip_sop_o,
    output logic [WORD_IW-1:0] word_idx_o,
    output logic [CHIP_IW-1:0] chip_idx_o,
    output logic [SYM_IW-1:0]  sym_idx_o,
    output logic [DAT_DW-1:0]  dat_cpri0_o,
    output logic [DAT_DW-1:0]  dat_cpri1_o,
    output logic [DAT_DW-1:0]  dat_cpri2_o,
    output logic [DAT_DW-1:0]  dat_cpri3_o,
    output logic [DAT_DW-1:0]  dat_cpri4_o,
    output logic [DAT_DW-1:0]  dat_cpri5_o,
    output logic [DAT_DW-1:0]  dat_cpri6_o,
    output logic [DAT_DW-1:0]  dat_cpri7_o,
    output logic               locked_o,
    output logic               sop_err_o
`ifdef CPRI_DEFRAME_STAT_EN
    ,
    output logic [15:0]        sop_err_cnt_o,
    output logic [15:0]        lock_loss_cnt_o
`endif
);

    logic [DAT_DW-1:0]  lane_in [LANES];
    logic [DAT_DW-1:0]  dat_p0_q [LANES];
    logic [DAT_DW-1:0]  dat_p1_q [LANES];
    logic               sop_p0_q;

    logic               fsm_locked, fsm_wrap, fsm_err, fsm_loss;
    logic [WORD_IW-1:0] fsm_word;

    logic [CHIP_IW-1:0] chip_cnt_q, chip_cnt_d;
    logic [SYM_IW-1:0]  sym_cnt_q, sym_cnt_d;

    logic               vld_q, sym_sop_q, chip_sop_q, locked_q, err_q;
    logic [WORD_IW-1:0] word_idx_q;
    logic [CHIP_IW-1:0] chip_idx_q;
    logic [SYM_IW-1:0]  sym_idx_q;

    assign lane_in[0] = dat_cpri0_i;
    assign lane_in[1] = dat_cpri1_i;
    assign lane_in[2] = dat_cpri2_i;
    assign lane_in[3] = dat_cpri3_i;
    assign lane_in[4] = dat_cpri4_i;
    assign lane_in[5] = dat_cpri5_i;
    assign lane_in[6] = dat_cpri6_i;
    assign lane_in[7] = dat_cpri7_i;

    // Stage p0: input register
    always_ff @(posedge clk) begin
        if (rst) begin
            sop_p0_q <= 1'b0;
            for (int i = 0; i < LANES; i++) dat_p0_q[i] <= '0;
        end else begin
            sop_p0_q <= sop_cpri_i;
            for (int i = 0; i < LANES; i++) dat_p0_q[i] <= lane_in[i];
        end
    end

    cpri_sop_lock_fsm #(
        .CHIP_LEN (CHIP_LEN),
        .LOCK_CNT (LOCK_CNT),
        .MISS_MAX (MISS_MAX)
    ) u_lock_fsm (
        .clk         (clk),
        .rst         (rst),
        .sop_i       (sop_p0_q),
        .locked_o    (fsm_locked),
        .word_idx_o  (fsm_word),
        .wrap_o      (fsm_wrap),
        .err_o       (fsm_err),
        .lock_loss_o (fsm_loss)
    );

    // Chip/symbol counters hold zero outside lock, so lock entry starts at chip 0 of symbol 0.
    always_comb begin
        chip_cnt_d = chip_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        if (!fsm_locked) begin
            chip_cnt_d = '0;
            sym_cnt_d  = '0;
        end else if (fsm_wrap) begin
            if (chip_cnt_q == CHIP_IW'(CHIP_PER_SYM - 1)) begin
                chip_cnt_d = '0;
                sym_cnt_d  = (sym_cnt_q == SYM_IW'(SYM_NUM - 1)) ? '0 : sym_cnt_q + SYM_IW'(1);
            end else begin
                chip_cnt_d = chip_cnt_q + CHIP_IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_cnt_q <= '0;
            sym_cnt_q  <= '0;
        end else begin
            chip_cnt_q <= chip_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
        end
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            chip_sop_q <= 1'b0;
            sym_sop_q  <= 1'b0;
            word_idx_q <= '0;
            chip_idx_q <= '0;
            sym_idx_q  <= '0;
            for (int i = 0; i < LANES; i++) dat_p1_q[i] <= '0;
        end else begin
            vld_q      <= fsm_locked;
            locked_q   <= fsm_locked;
            err_q      <= fsm_err;
            chip_sop_q <= fsm_locked && (fsm_word == '0);
            sym_sop_q  <= fsm_locked && (fsm_word == '0) && (chip_cnt_q == '0);
            word_idx_q <= fsm_word;
            chip_idx_q <= chip_cnt_q;
            sym_idx_q  <= sym_cnt_q;
            for (int i = 0; i < LANES; i++) dat_p1_q[i] <= dat_p0_q[i];
        end
    end

    assign vld_o       = vld_q;
    assign locked_o    = locked_q;
    assign sop_err_o   = err_q;
    assign chip_sop_o  = chip_sop_q;
    assign sym_sop_o   = sym_sop_q;
    assign word_idx_o  = word_idx_q;
    assign chip_idx_o  = chip_idx_q;
    assign sym_idx_o   = sym_idx_q;
    assign dat_cpri0_o = dat_p1_q[0];
    assign dat_cpri1_o = dat_p1_q[1];
    assign dat_cpri2_o = dat_p1_q[2];
    assign dat_cpri3_o = dat_p1_q[3];
    assign dat_cpri4_o = dat_p1_q[4];
    assign dat_cpri5_o = dat_p1_q[5];
    assign dat_cpri6_o = dat_p1_q[6];
    assign dat_cpri7_o = dat_p1_q[7];

`ifdef CPRI_DEFRAME_STAT_EN
    logic [15:0] err_cnt_q, loss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            loss_cnt_q <= '0;
        end else begin
            if (fsm_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (fsm_loss && loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 16'd1;
        end
    end

    assign sop_err_cnt_o   = err_cnt_q;
    assign lock_loss_cnt_o = loss_cnt_q;
`else
    logic unused_fsm_loss;
    assign unused_fsm_loss = fsm_loss;
`endif

endmodule

// File: tb/tb_cpri_chip_deframer.sv
// Self-checking bench for cpri_chip_deframer: random lane data, directed SOP schedules, behavioural model.
module tb_cpri_chip_deframer;

    localparam int CL    = 96;
    localparam int CPS   = 132;
    localparam int SN    = 5;
    localparam int LOCK  = 3;
    localparam int MISSM = 2;

    typedef struct packed {
        logic         vld;
        logic         locked;
        logic         err;
        logic         chip_sop;
        logic         sym_sop;
        logic [6:0]   w;
        logic [7:0]   c;
        logic [2:0]   s;
        logic [15:0]  ec;
        logic [15:0]  lc;
        logic [511:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sop_i;
    logic [63:0] din  [8];
    logic [63:0] dout [8];
    logic        vld_o, sym_sop_o, chip_sop_o, locked_o, sop_err_o;
    logic [6:0]  word_idx_o;
    logic [7:0]  chip_idx_o;
    logic [2:0]  sym_idx_o;
`ifdef CPRI_DEFRAME_STAT_EN
    logic [15:0] sop_err_cnt_o, lock_loss_cnt_o;
`endif

    always #5 clk = ~clk;

    cpri_chip_deframer dut (
        .clk         (clk),
        .rst         (rst),
        .sop_cpri_i  (sop_i),
        .dat_cpri0_i (din[0]),
        .dat_cpri1_i (din[1]),
        .dat_cpri2_i (din[2]),
        .dat_cpri3_i (din[3]),
        .dat_cpri4_i (din[4]),
        .dat_cpri5_i (din[5]),
        .dat_cpri6_i (din[6]),
        .dat_cpri7_i (din[7]),
        .vld_o       (vld_o),
        .sym_sop_o   (sym_sop_o),
        .chip_sop_o  (chip_sop_o),
        .word_idx_o  (word_idx_o),
        .chip_idx_o  (chip_idx_o),
        .sym_idx_o   (sym_idx_o),
        .dat_cpri0_o (dout[0]),
        .dat_cpri1_o (dout[1]),
        .dat_cpri2_o (dout[2]),
        .dat_cpri3_o (dout[3]),
        .dat_cpri4_o (dout[4]),
        .dat_cpri5_o (dout[5]),
        .dat_cpri6_o (dout[6]),
        .dat_cpri7_o (dout[7]),
        .locked_o    (locked_o),
`ifdef CPRI_DEFRAME_STAT_EN
        .sop_err_cnt_o   (sop_err_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
`endif
        .sop_err_o   (sop_err_o)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    int   err_seen = 0;
    bit   saw_sym4 = 0;
    bit   saw_sym_wrap = 0;
    exp_t ep;

    // Reference model: 0 = hunting, 1 = verifying, 2 = locked
    int m_mode, m_pos, m_good, m_miss, m_chip, m_sym, m_ec, m_lc;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_chip = 0; m_sym = 0; m_ec = 0; m_lc = 0;
    endtask

    task automatic model(input bit sop, input logic [511:0] d, output exp_t e);
        int w;
        bit was_locked, lock_now, err;
        e = '0;
        e.data = d;
        was_locked = (m_mode == 2);
        lock_now = 0;
        err = 0;
        w = (m_mode != 2 && sop) ? 0 : m_pos;
        if (m_mode == 0) begin
            if (sop) begin
                m_good = 1;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (sop) begin
                m_good = (m_pos == 0) ? m_good + 1 : 1;
                if (m_good >= LOCK) begin
                    m_mode = 2; lock_now = 1; m_miss = 0; m_chip = 0; m_sym = 0; m_good = 0;
                end
            end else if (m_pos == 0) begin
                m_mode = 0;
            end
        end else begin
            if (sop && w == 0) begin
                m_miss = 0;
            end else if (sop || w == 0) begin
                err = 1;
                m_miss++;
                if (m_ec < 65535) m_ec++;
                if (m_miss >= MISSM) begin
                    m_mode = 0; m_miss = 0;
                    if (m_lc < 65535) m_lc++;
                end
            end
        end
        e.vld      = was_locked || lock_now;
        e.locked   = e.vld;
        e.err      = err;
        e.w        = 7'(w);
        e.c        = 8'(m_chip);
        e.s        = 3'(m_sym);
        e.chip_sop = e.vld && (w == 0);
        e.sym_sop  = e.chip_sop && (m_chip == 0);
        e.ec       = 16'(m_ec);
        e.lc       = 16'(m_lc);
        if (e.vld && w == CL - 1) begin
            m_chip++;
            if (m_chip == CPS) begin
                m_chip = 0;
                m_sym = (m_sym + 1) % SN;
            end
        end
        m_pos = (w + 1) % CL;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] out_data();
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = dout[i];
        return d;
    endfunction

    task automatic check_exp(input exp_t e);
        check("vld", 512'(vld_o), 512'(e.vld));
        check("locked", 512'(locked_o), 512'(e.locked));
        check("sop_err", 512'(sop_err_o), 512'(e.err));
        check("chip_sop", 512'(chip_sop_o), 512'(e.chip_sop));
        check("sym_sop", 512'(sym_sop_o), 512'(e.sym_sop));
        check("data", out_data(), e.data);
        if (e.vld) begin
            check("word_idx", 512'(word_idx_o), 512'(e.w));
            check("chip_idx", 512'(chip_idx_o), 512'(e.c));
            check("sym_idx", 512'(sym_idx_o), 512'(e.s));
        end
`ifdef CPRI_DEFRAME_STAT_EN
        check("sop_err_cnt", 512'(sop_err_cnt_o), 512'(e.ec));
        check("lock_loss_cnt", 512'(lock_loss_cnt_o), 512'(e.lc));
`endif
        if (sop_err_o === 1'b1) err_seen++;
        if (vld_o === 1'b1 && sym_idx_o == 3'd4) saw_sym4 = 1;
        if (saw_sym4 && vld_o === 1'b1 && sym_idx_o == 3'd0) saw_sym_wrap = 1;
    endtask

    task automatic check_zero();
        check("rst_vld", 512'(vld_o), 512'(0));
        check("rst_locked", 512'(locked_o), 512'(0));
        check("rst_sop_err", 512'(sop_err_o), 512'(0));
        check("rst_flags", 512'({chip_sop_o, sym_sop_o}), 512'(0));
        check("rst_idx", 512'({word_idx_o, chip_idx_o, sym_idx_o}), 512'(0));
        check("rst_data", out_data(), 512'(0));
    endtask

    task automatic step(input bit sop, input bit r);
        exp_t en;
        logic [511:0] d;
        for (int i = 0; i < 8; i++) begin
            din[i] = {$urandom, $urandom};
            d[i*64 +: 64] = din[i];
        end
        sop_i = sop;
        rst = r;
        if (r) begin
            model_reset();
            model(1'b0, 512'(0), en);
        end else begin
            model(sop, d, en);
        end
        @(posedge clk);
        #1;
        if (r) check_zero();
        else check_exp(ep);
        ep = en;
    endtask

    task automatic run_chip(input bit sop0, input int stray);
        for (int i = 0; i < CL; i++) step((i == 0 && sop0) || (i == stray), 1'b0);
    endtask

    initial begin
        sop_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = '0;
        model_reset();

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Lock, then run past a full 5-symbol pattern period
        for (int k = 0; k < LOCK + CPS * SN + 2; k++) run_chip(1'b1, -1);
        check("sym_wrap_seen", 512'({saw_sym4, saw_sym_wrap}), 512'(2'b11));
        check("clean_err_pulses", 512'(err_seen), 512'(0));

        // Single dropped SOP: lock held
        run_chip(1'b0, -1);
        run_chip(1'b1, -1);
        check("single_drop_pulses", 512'(err_seen), 512'(1));
        check("single_drop_locked", 512'(locked_o), 512'(1));
        run_chip(1'b1, -1);

        // Two consecutive drops: lock lost, then reacquired
        run_chip(1'b0, -1);
        run_chip(1'b0, -1);
        check("double_drop_locked", 512'(locked_o), 512'(0));
        for (int k = 0; k < LOCK + 1; k++) run_chip(1'b1, -1);

        // Stray SOP at word 40 while locked
        run_chip(1'b1, 40);
        run_chip(1'b1, -1);
        run_chip(1'b1, -1);
        check("stray_locked", 512'(locked_o), 512'(1));

        // One-cycle reset at word 50, then reacquire
        for (int i = 0; i < CL; i++) step(i == 0, i == 50);
        for (int k = 0; k < LOCK + 1; k++) run_chip(1'b1, -1);
        check("relock_after_rst", 512'(locked_o), 512'(1));

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
